maxnet_engine: RTL and testbench
================================

# maxnet_engine

- Parametrised Maxnet winner-take-all engine for N unsigned fixed-point activations.
- Each iteration applies lateral inhibition to every channel: a_i ← max(0, a_i − ⌊eps·(S − a_i)⌋), where S is the sum of all activations at the start of the iteration.
- The engine iterates until at most one activation is nonzero or an iteration cap is reached, then reports the winner index and value.
- It is the N-channel, width-generic successor of the fixed 4-input Maxnet model. It adds no-winner and timeout reporting and uses a time-multiplexed single-multiplier datapath.

## Interface
- N, 4: channel count, ≥2.
- W, 16: activation width, unsigned integer.
- FRAC, 8: fractional bits of eps; eps is unsigned Q0.FRAC, FRAC-bit wide.
- MAX_ITER, 64: iteration cap, ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled only in IDLE or DONE.
- eps  in  FRAC  inhibition weight, captured on accepted start.
- a_in  in  N*W  initial activations; channel k is a_in[k*W +: W]; captured on accepted start.
- busy  out  1  high in CHECK and UPDATE.
- done  out  1  one-cycle pulse on entry to DONE.
- winner_valid  out  1  exactly one activation is nonzero.
- no_winner  out  1  all activations are zero.
- timeout  out  1  cap reached with ≥2 nonzero activations.
- winner_idx  out  $clog2(N)  winner channel; 0 unless winner_valid.
- winner_val  out  W  winner activation; 0 unless winner_valid.
- iter_count  out  $clog2(MAX_ITER+1)  completed iterations.
- Reset values: all outputs 0; FSM in IDLE; activation registers 0.

## Operation
- **States:** IDLE, CHECK, UPDATE, DONE.
- **Start:** in IDLE or DONE, start=1 loads a_in, eps, clears iter_count and result flags, then moves to CHECK. start is ignored in CHECK and UPDATE.
- **CHECK:**
  - Count the nonzero activations and compute S with a full-precision adder tree, W+$clog2(N) bits.
  - Latch S into s_reg.
  - If count==1: winner_valid=1, winner_idx/winner_val are set from that channel, go to DONE.
  - Else if count==0: no_winner=1, go to DONE.
  - Else if iter_count==MAX_ITER: timeout=1, go to DONE.
  - Else go to UPDATE with k=0.
- **UPDATE:** one channel per cycle, k = 0..N−1, using one shared multiplier.
  - p = eps·(s_reg − a_k), full width.
  - inh = p >> FRAC, truncating (floor).
  - a_k ← (inh ≥ a_k) ? 0 : a_k − inh.
  - In-place update is exact because s_reg holds the old sum and each new a_k depends only on the old a_k.
  - After k=N−1: iter_count+1, return to CHECK.
- **Arithmetic:** no wrap is possible; the clamp at 0 is the only saturation. Result flags are mutually exclusive.
- **DONE:** result outputs hold until the next accepted start or reset.
- **eps=0:** no progress; the run ends with timeout if ≥2 activations are nonzero.
- **Ties:** equal maxima decay identically. The run ends with no_winner, or timeout if truncation stalls the decay.

## Timing
- Start accepted at edge 0 → CHECK in cycle 1.
- Each iteration is N+1 cycles (CHECK plus N UPDATE).
- done is high in cycle 2 + iters·(N+1) and lasts exactly one cycle.
- busy falls in the same cycle done rises.
- Asynchronous reset mid-run immediately returns all state and outputs to reset values. No partial result is retained.
- start held high in DONE restarts the run at the next edge; done does not re-pulse until that run completes.

## Structure
- Package maxnet_pkg holds:
  - the state enum (IDLE/CHECK/UPDATE/DONE);
  - a result-code localparam set;
  - a width helper function for the sum width W+$clog2(N).
- One natural sub-module: maxnet_inhibit_unit. It is combinational and implements subtract, multiply, shift and clamp for one channel; it is instantiated once.
- The FSM, activation register array, adder tree and channel counter live in maxnet_engine.

## Test plan
- **Single nonzero:** N=4, a={0,0,5,0}, any eps → done in cycle 2; winner_valid=1, winner_idx=2, winner_val=5, iter_count=0.
- **All zero:** a={0,0,0,0} → done in cycle 2; no_winner=1, winner_idx=0, winner_val=0.
- **Normal convergence:** a={100,80,60,40}, eps=0x20.
  - After iteration 1: a={78,55,33,10}.
  - After iteration 2: a={66,40,16,0}.
  - The run ends with winner_valid=1 and winner_idx=0; the bench checks each iteration against a reference model.
- **Stalled tie:** a={50,50,0,0}, eps=0x80, MAX_ITER=16.
  - Sequence 25, 13, 7, 4, 2, 1, 1, …
  - timeout=1, iter_count=16, done in cycle 2+16·5=82.
- **Reset mid-UPDATE:** assert rst_n=0 during iteration 1 → all outputs 0 at once, state IDLE. A new start then produces a correct result.
- **start while busy:** start pulses in CHECK/UPDATE are ignored and the result is unchanged. start held in DONE restarts with the new a_in.

Source files
------------

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared FSM states, result codes and width helper for the Maxnet engine
package maxnet_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DONE} state_t;

    localparam logic [1:0] RES_NONE      = 2'd0;
    localparam logic [1:0] RES_WINNER    = 2'd1;
    localparam logic [1:0] RES_NO_WINNER = 2'd2;
    localparam logic [1:0] RES_TIMEOUT   = 2'd3;

    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/maxnet_inhibit_unit.sv
// maxnet_inhibit_unit: one-channel lateral inhibition a - floor(eps*(s-a)), clamped at zero
module maxnet_inhibit_unit #(
    parameter int W    = 16,
    parameter int SW   = 18,
    parameter int FRAC = 8
) (
    input  logic [W-1:0]    a,
    input  logic [SW-1:0]   s,
    input  logic [FRAC-1:0] eps,
    output logic [W-1:0]    a_next
);
    logic [SW+FRAC-1:0] p;
    logic [SW-1:0]      inh;

    always_comb begin
        p      = (SW+FRAC)'(eps) * (SW+FRAC)'(s - SW'(a));
        inh    = SW'(p >> FRAC);
        a_next = (inh >= SW'(a)) ? '0 : a - inh[W-1:0];
    end

endmodule

// File: rtl/maxnet_engine.sv
// maxnet_engine: N-channel Maxnet winner-take-all, one shared inhibit unit stepping channels per cycle
module maxnet_engine import maxnet_pkg::*; #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int FRAC     = 8,
    parameter int MAX_ITER = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [FRAC-1:0]               eps,
    input  logic [N*W-1:0]                a_in,
    output logic                          busy,
    output logic                          done,
    output logic                          winner_valid,
    output logic                          no_winner,
    output logic                          timeout,
    output logic [$clog2(N)-1:0]          winner_idx,
    output logic [W-1:0]                  winner_val,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);
    localparam int SW = sum_width(W, N);
    localparam int KW = $clog2(N);
    localparam int IW = $clog2(MAX_ITER+1);
    localparam int CW = $clog2(N+1);

    state_t          state, state_nxt;
    logic [W-1:0]    a_reg [N];
    logic [FRAC-1:0] eps_reg;
    logic [SW-1:0]   s_reg, sum;
    logic [KW-1:0]   k, nz_idx;
    logic [CW-1:0]   nz_cnt;
    logic [W-1:0]    nz_val, a_upd;
    logic [1:0]      res, chk_res;
    logic            start_acc;

    always_comb begin
        sum    = '0;
        nz_cnt = '0;
        nz_idx = '0;
        nz_val = '0;
        for (int i = 0; i < N; i++) begin
            sum    = sum + SW'(a_reg[i]);
            nz_cnt = nz_cnt + CW'(a_reg[i] != '0);
            if (a_reg[i] != '0) begin
                nz_idx = KW'(i);
                nz_val = a_reg[i];
            end
        end
    end

    // Priority order makes the result codes mutually exclusive
    assign chk_res = (nz_cnt == CW'(1)) ? RES_WINNER :
                     (nz_cnt == '0) ? RES_NO_WINNER :
                     (iter_count == IW'(MAX_ITER)) ? RES_TIMEOUT : RES_NONE;

    assign start_acc = start && (state == IDLE || state == DONE);

    maxnet_inhibit_unit #(.W(W), .SW(SW), .FRAC(FRAC)) u_inhibit (
        .a      (a_reg[k]),
        .s      (s_reg),
        .eps    (eps_reg),
        .a_next (a_upd)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? CHECK : state;
            CHECK:      state_nxt = (chk_res != RES_NONE) ? DONE : UPDATE;
            UPDATE:     state_nxt = (k == KW'(N-1)) ? CHECK : UPDATE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = state == CHECK || state == UPDATE;
        winner_valid = res == RES_WINNER;
        no_winner    = res == RES_NO_WINNER;
        timeout      = res == RES_TIMEOUT;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < N; i++) a_reg[i] <= '0;
            eps_reg    <= '0;
            s_reg      <= '0;
            k          <= '0;
            iter_count <= '0;
            res        <= RES_NONE;
            winner_idx <= '0;
            winner_val <= '0;
            done       <= 1'b0;
        end else begin
            done <= state_nxt == DONE && state != DONE;
            if (start_acc) begin
                for (int i = 0; i < N; i++) a_reg[i] <= a_in[i*W +: W];
                eps_reg    <= eps;
                iter_count <= '0;
                res        <= RES_NONE;
                winner_idx <= '0;
                winner_val <= '0;
            end
            if (state == CHECK) begin
                s_reg <= sum;
                k     <= '0;
                res   <= chk_res;
                if (chk_res == RES_WINNER) begin
                    winner_idx <= nz_idx;
                    winner_val <= nz_val;
                end
            end
            // s_reg keeps the old sum, so updating channels in place is exact
            if (state == UPDATE) begin
                a_reg[k] <= a_upd;
                k        <= k + 1'b1;
                if (k == KW'(N-1)) iter_count <= iter_count + 1'b1;
            end
        end

endmodule

// File: tb/tb_maxnet_engine.sv
// tb_maxnet_engine: table vectors, hand sequences and random runs against a Maxnet reference model
module tb_maxnet_engine;
    localparam int N = 4, W = 16, FRAC = 8, MAX_ITER = 16;

    logic                          clk = 0, rst_n = 0, start = 0;
    logic [FRAC-1:0]               eps = '0;
    logic [N*W-1:0]                a_in = '0;
    logic                          busy, done, winner_valid, no_winner, timeout;
    logic [$clog2(N)-1:0]          winner_idx;
    logic [W-1:0]                  winner_val;
    logic [$clog2(MAX_ITER+1)-1:0] iter_count;

    maxnet_engine #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eps(eps), .a_in(a_in),
        .busy(busy), .done(done), .winner_valid(winner_valid), .no_winner(no_winner),
        .timeout(timeout), .winner_idx(winner_idx), .winner_val(winner_val), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0]  a;
        logic [FRAC-1:0] e;
        int res;
        int idx;
        int val;
        int iters;
    } vec_t;

    int n_cmp = 0, n_fail = 0;
    longint m [N];
    vec_t tbl [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic void load_model(input logic [N*W-1:0] av);
        for (int i = 0; i < N; i++) m[i] = longint'(av[i*W +: W]);
    endfunction

    function automatic void iterate(input logic [FRAC-1:0] e);
        longint s, inh;
        s = 0;
        for (int i = 0; i < N; i++) s += m[i];
        for (int i = 0; i < N; i++) begin
            inh  = (longint'(e) * (s - m[i])) / (longint'(1) << FRAC);
            m[i] = (inh >= m[i]) ? 0 : m[i] - inh;
        end
    endfunction

    // res: 1 winner, 2 no winner, 3 timeout
    task automatic predict(input logic [N*W-1:0] av, input logic [FRAC-1:0] ev, output vec_t v);
        int nz, li;
        v.a = av; v.e = ev; v.res = 0; v.idx = 0; v.val = 0; v.iters = 0;
        load_model(av);
        while (v.res == 0) begin
            nz = 0; li = 0;
            for (int i = 0; i < N; i++) if (m[i] != 0) begin nz++; li = i; end
            if (nz == 1) begin v.res = 1; v.idx = li; v.val = int'(m[li]); end
            else if (nz == 0) v.res = 2;
            else if (v.iters == MAX_ITER) v.res = 3;
            else begin iterate(ev); v.iters++; end
        end
    endtask

    task automatic run(input logic [N*W-1:0] av, input logic [FRAC-1:0] ev,
                       input int g0, input int g1, output int cyc);
        int it;
        @(negedge clk); start = 1; a_in = av; eps = ev;
        @(posedge clk); #1; start = 0; cyc = 1; it = 0;
        load_model(av);
        while (!done && cyc < 400) begin
            start = cyc >= g0 && cyc <= g1;
            a_in  = start ? ~av : av;
            @(posedge clk); #1; cyc++;
            if (int'(iter_count) != it) begin
                iterate(ev); it++;
                for (int i = 0; i < N; i++) chk($sformatf("act_it%0d_ch%0d", it, i), longint'(dut.a_reg[i]), m[i]);
            end
        end
        start = 0; a_in = av;
        if (!done) chk("done_wait", 0, 1);
    endtask

    task automatic check_result(input string nm, input vec_t v, input int cyc);
        chk({nm, "_cycle"}, cyc, 2 + v.iters * (N + 1));
        chk({nm, "_done"}, done, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, winner_valid, v.res == 1);
        chk({nm, "_nowin"}, no_winner, v.res == 2);
        chk({nm, "_tmo"}, timeout, v.res == 3);
        chk({nm, "_idx"}, winner_idx, v.idx);
        chk({nm, "_val"}, winner_val, v.val);
        chk({nm, "_iters"}, iter_count, v.iters);
    endtask

    initial begin
        int cyc;
        vec_t v;
        tbl[0] = '{pk(0, 0, 5, 0),        8'h55, 1, 2, 5,  0};
        tbl[1] = '{pk(0, 0, 0, 0),        8'h20, 2, 0, 0,  0};
        tbl[2] = '{pk(100, 80, 60, 40),   8'h20, 1, 0, 50, 8};
        tbl[3] = '{pk(50, 50, 0, 0),      8'h80, 3, 0, 0,  16};
        tbl[4] = '{pk(300, 200, 0, 0),    8'h00, 3, 0, 0,  16};
        tbl[5] = '{pk(10, 10, 10, 10),    8'hff, 2, 0, 0,  1};
        tbl[6] = '{pk(0, 0, 0, 7),        8'h10, 1, 3, 7,  0};

        #23;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {winner_valid, no_winner, timeout}, 0);
        chk("rst_idx_val", {winner_idx, winner_val}, 0);
        chk("rst_iter", iter_count, 0);
        @(negedge clk); rst_n = 1;

        foreach (tbl[t]) begin
            run(tbl[t].a, tbl[t].e, 0, -1, cyc);
            check_result($sformatf("vec%0d", t), tbl[t], cyc);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse", t), done, 0);
            chk($sformatf("vec%0d_hold", t), winner_val, tbl[t].val);
        end

        // start pulses while busy are ignored
        run(tbl[2].a, tbl[2].e, 1, 6, cyc);
        check_result("busy_start", tbl[2], cyc);

        // start held in DONE restarts with the new activations
        start = 1; a_in = pk(0, 9, 0, 0);
        @(posedge clk); #1;
        chk("hold_done_low", done, 0);
        chk("hold_busy", busy, 1);
        chk("hold_cleared", winner_valid, 0);
        start = 0;
        @(posedge clk); #1;
        chk("hold_done", done, 1);
        chk("hold_idx", winner_idx, 1);
        chk("hold_val", winner_val, 9);

        // asynchronous reset in the middle of the first UPDATE pass
        @(negedge clk); start = 1; a_in = tbl[2].a; eps = tbl[2].e;
        @(posedge clk); #1; start = 0;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1);
        #2; rst_n = 0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_flags", {done, winner_valid, no_winner, timeout}, 0);
        chk("mid_rst_iter", iter_count, 0);
        chk("mid_rst_act", dut.a_reg[0], 0);
        @(negedge clk); rst_n = 1;
        run(tbl[0].a, tbl[0].e, 0, -1, cyc);
        check_result("post_rst", tbl[0], cyc);

        for (int r = 0; r < 20; r++) begin
            logic [N*W-1:0] av;
            for (int i = 0; i < N; i++) av[i*W +: W] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 400));
            predict(av, 8'($urandom_range(0, 255)), v);
            run(v.a, v.e, 0, -1, cyc);
            check_result($sformatf("rnd%0d", r), v, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
